// File: rtl/bcd_digit_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding the per-digit
// seven-segment decoders; emits saturated BCD nibbles plus a leading-zero blank mask.

module bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_digit_driver #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_value,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank,
   output logic                  overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] MAXV  = pow10(DIGITS) - 64'd1;
   localparam logic [63:0] MAXIN = (64'd1 << WIDTH) - 64'd1;
   // overflow detection is only built when the input range can exceed the display
   localparam bit          OVF_EN = (MAXIN > MAXV);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   logic [1:0]                state;
   logic [WIDTH-1:0]          bin;
   logic [DIGITS-1:0][3:0]    acc;
   logic [DIGITS-1:0][3:0]    adj;
   logic [4*DIGITS-1:0]       adj_flat;
   logic [CW-1:0]             cnt;
   logic                      ovf_latch;
   logic                      ovf_in;
   logic [DIGITS-1:0][3:0]    res;
   logic [DIGITS-1:0]         blank_nxt;
   logic                      seen;
   logic [DIGITS-1:0][3:0]    bcd_q;

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      bcd_add3 u_add3 (
         .d (acc[k]),
         .q (adj[k])
      );
   end

   assign adj_flat = adj;
   assign ovf_in   = OVF_EN && (64'(in_value) > MAXV);
   assign in_ready = (state == S_IDLE);
   assign bcd      = bcd_q;

   assign res = ovf_latch ? {DIGITS{4'h9}} : acc;

   // a digit is blanked while it and everything above it is zero; units always shown
   always_comb begin
      blank_nxt = '0;
      seen      = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         seen         = seen | (res[k] != 4'h0);
         blank_nxt[k] = ~seen;
      end
      blank_nxt[0] = 1'b0;
      if (ovf_latch) blank_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         bin       <= '0;
         acc       <= '0;
         cnt       <= '0;
         ovf_latch <= 1'b0;
         out_valid <= 1'b0;
         bcd_q     <= '0;
         blank     <= BLANK_RST;
         overflow  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  bin       <= in_value;
                  acc       <= '0;
                  cnt       <= CW'(WIDTH);
                  ovf_latch <= ovf_in;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               acc <= {adj_flat[4*DIGITS-2:0], bin[WIDTH-1]};
               bin <= bin << 1;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= S_FINISH;
            end
            S_FINISH: begin
               bcd_q     <= res;
               overflow  <= ovf_latch;
               blank     <= blank_nxt;
               out_valid <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_digit_driver.sv
// Scoreboard bench: two converters (5 and 4 digits) share one stimulus stream and are
// compared against an arithmetic decimal model with per-result latency checks.

module tb_bcd_digit_driver;

   typedef struct {
      logic [19:0] bcd;
      logic [4:0]  blank;
      logic        ovf;
      longint      t;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in_value;
   logic        in_ready5, out_valid5, overflow5;
   logic [19:0] bcd5;
   logic [4:0]  blank5;
   logic        in_ready4, out_valid4, overflow4;
   logic [15:0] bcd4;
   logic [3:0]  blank4;

   int checks = 0;
   int errors = 0;
   exp_t q5[$];
   exp_t q4[$];

   localparam longint LAT = 175;

   always #5 clk = ~clk;

   bcd_digit_driver #(.WIDTH(16), .DIGITS(5)) u_dut5 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready5),
      .in_value(in_value), .out_valid(out_valid5), .bcd(bcd5), .blank(blank5),
      .overflow(overflow5)
   );

   bcd_digit_driver #(.WIDTH(16), .DIGITS(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
      .in_value(in_value), .out_valid(out_valid4), .bcd(bcd4), .blank(blank4),
      .overflow(overflow4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input longint v, input int d, input longint t);
      exp_t   e;
      longint p;
      longint maxv;
      e.bcd = '0; e.blank = '0; e.ovf = 1'b0; e.t = t;
      maxv = 1;
      for (int i = 0; i < d; i++) maxv = maxv * 10;
      maxv = maxv - 1;
      p = 1;
      if (v > maxv) begin
         e.ovf = 1'b1;
         for (int k = 0; k < d; k++) e.bcd[4*k +: 4] = 4'h9;
      end else begin
         for (int k = 0; k < d; k++) begin
            e.bcd[4*k +: 4] = 4'((v / p) % 10);
            e.blank[k]      = (k > 0) && (v < p);
            p = p * 10;
         end
      end
      return e;
   endfunction

   task automatic chk_reset_state();
      chk("rst_ready5", 32'(in_ready5), 32'd1);
      chk("rst_valid5", 32'(out_valid5), 32'd0);
      chk("rst_bcd5", 32'(bcd5), 32'h0);
      chk("rst_blank5", 32'(blank5), 32'h1e);
      chk("rst_ovf5", 32'(overflow5), 32'd0);
      chk("rst_ready4", 32'(in_ready4), 32'd1);
      chk("rst_valid4", 32'(out_valid4), 32'd0);
      chk("rst_bcd4", 32'(bcd4), 32'h0);
      chk("rst_blank4", 32'(blank4), 32'he);
      chk("rst_ovf4", 32'(overflow4), 32'd0);
   endtask

   // called at posedge+1; holds value until accepted, optionally jittering while busy
   task automatic send(input logic [15:0] v, input bit noise);
      for (int i = 0; i < 100; i++) begin
         if (in_ready5) begin
            in_valid = 1'b1;
            in_value = v;
            q5.push_back(model(longint'(v), 5, $time + 9));
            q4.push_back(model(longint'(v), 4, $time + 9));
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_value = 16'($urandom());
            return;
         end
         if (noise) begin
            in_valid = 1'b1;
            in_value = 16'($urandom());
         end
         @(posedge clk); #1;
      end
      chk("send_timeout", 32'd0, 32'd1);
   endtask

   always @(negedge clk) begin
      exp_t   e;
      longint now;
      now = $time;
      if (reset_n) begin
         chk("ready5", 32'(in_ready5),
             32'((q5.size() == 0) || (now < q5[0].t) || (now >= q5[0].t + LAT)));
         if (out_valid5) begin
            if (q5.size() == 0) chk("spurious5", 32'd1, 32'd0);
            else begin
               e = q5.pop_front();
               chk("lat5", 32'(now - e.t), 32'(LAT));
               chk("bcd5", 32'(bcd5), 32'(e.bcd));
               chk("blank5", 32'(blank5), 32'(e.blank));
               chk("ovf5", 32'(overflow5), 32'(e.ovf));
            end
         end else if (q5.size() > 0 && now > q5[0].t + LAT) begin
            e = q5.pop_front();
            chk("late5", 32'd0, 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      exp_t   e;
      longint now;
      now = $time;
      if (reset_n) begin
         chk("ready4", 32'(in_ready4),
             32'((q4.size() == 0) || (now < q4[0].t) || (now >= q4[0].t + LAT)));
         if (out_valid4) begin
            if (q4.size() == 0) chk("spurious4", 32'd1, 32'd0);
            else begin
               e = q4.pop_front();
               chk("lat4", 32'(now - e.t), 32'(LAT));
               chk("bcd4", 32'(bcd4), 32'(e.bcd[15:0]));
               chk("blank4", 32'(blank4), 32'(e.blank[3:0]));
               chk("ovf4", 32'(overflow4), 32'(e.ovf));
            end
         end else if (q4.size() > 0 && now > q4[0].t + LAT) begin
            e = q4.pop_front();
            chk("late4", 32'd0, 32'd1);
         end
      end
   end

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_value = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk_reset_state();
      @(posedge clk); #1;

      send(16'd1234, 1'b0);
      send(16'd0, 1'b0);
      send(16'd65535, 1'b0);
      send(16'd12345, 1'b0);
      send(16'd7, 1'b0);
      send(16'd500, 1'b0);
      send(16'd321, 1'b1);
      send(16'd9999, 1'b0);
      send(16'd10000, 1'b0);
      send(16'd999, 1'b0);

      // abort a conversion mid-shift
      repeat (5) @(posedge clk);
      #1 reset_n = 1'b0;
      q5.delete();
      q4.delete();
      @(negedge clk);
      chk_reset_state();
      @(posedge clk); #1 reset_n = 1'b1;
      send(16'd42, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] v;
         case ($urandom_range(0, 3))
            0:       v = 16'($urandom_range(0, 9));
            1:       v = 16'($urandom_range(0, 999));
            2:       v = 16'($urandom_range(9990, 10010));
            default: v = 16'($urandom());
         endcase
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send(v, 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 40 && (q5.size() != 0 || q4.size() != 0); i++) @(posedge clk);
      @(negedge clk); #1;
      chk("drain5", 32'(q5.size()), 32'd0);
      chk("drain4", 32'(q4.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
